// File: rtl/ro_puf_reader_if.sv
// Start/done handshake and result bus between the RO-PUF reader and key-generation logic.
// With PUF_MARGIN_EN defined the bus also carries the unstable flag.
interface ro_puf_reader_if #(
  parameter int N_RO = 16,
  parameter int CW   = 16
);
  localparam int SW = (N_RO > 1) ? $clog2(N_RO) : 1;

  logic          start;
  logic [SW-1:0] sel_a;
  logic [SW-1:0] sel_b;
  logic          busy;
  logic          done;
  logic          resp;
  logic [CW-1:0] diff;
`ifdef PUF_MARGIN_EN
  logic          unstable;

  modport master (output start, sel_a, sel_b, input busy, done, resp, diff, unstable);
  modport slave  (input start, sel_a, sel_b, output busy, done, resp, diff, unstable);
`else
  modport master (output start, sel_a, sel_b, input busy, done, resp, diff);
  modport slave  (input start, sel_a, sel_b, output busy, done, resp, diff);
`endif
endinterface

// File: rtl/ro_puf_reader.sv
// Ring-oscillator PUF evaluator: counts rising edges of two selected oscillators over a
// fixed window and reports the comparison bit and |difference|. Optional PUF_MARGIN_EN adds unstable.
//
// state  | meaning
// IDLE   | waiting for start; results from the last evaluation hold
// SETTLE | rings enabled, edges ignored while oscillators stabilise
// COUNT  | rings enabled, selected edges counted for WINDOW cycles
// DONE   | final counts stable; results registered on leaving this state
module ro_puf_reader #(
  parameter int N_RO   = 16,
  parameter int CW     = 16,
  parameter int WINDOW = 1024,
  parameter int SETTLE = 16,
  parameter int MARGIN = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_RO-1:0] ro_in,
  output logic            ro_en,
  ro_puf_reader_if.slave  bus
);
  localparam int SW   = (N_RO > 1) ? $clog2(N_RO) : 1;
  localparam int NX   = 2 ** SW;
  localparam int TMAX = (WINDOW > SETTLE) ? WINDOW : SETTLE;
  localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETTLE = 2'd1;
  localparam logic [1:0] ST_COUNT  = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  generate
    if (WINDOW < 1 || SETTLE < 1 || MARGIN < 0) begin : g_bad_param
      $error("ro_puf_reader: WINDOW and SETTLE must be >= 1, MARGIN >= 0");
    end
  endgenerate

  logic [1:0]      state;
  logic [TW-1:0]   tmr;
  logic [SW-1:0]   sel_a_q;
  logic [SW-1:0]   sel_b_q;
  logic [CW-1:0]   cnt_a;
  logic [CW-1:0]   cnt_b;
  logic [CW-1:0]   absdiff;
  logic [N_RO-1:0] sync1;
  logic [N_RO-1:0] sync2;
  logic [N_RO-1:0] sync3;
  logic [NX-1:0]   rise_x;
  logic            edge_a;
  logic            edge_b;
  logic            done_q;
  logic            resp_q;
  logic [CW-1:0]   diff_q;

  // Synchronizers run regardless of state so the first counted edge is already clean.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
      sync3 <= '0;
    end else begin
      sync1 <= ro_in;
      sync2 <= sync1;
      sync3 <= sync2;
    end
  end

  // Out-of-range select indices land on the zero padding and never count.
  always_comb begin
    rise_x = '0;
    rise_x[N_RO-1:0] = sync2 & ~sync3;
  end

  assign edge_a  = rise_x[sel_a_q];
  assign edge_b  = rise_x[sel_b_q];
  assign absdiff = (cnt_a > cnt_b) ? (cnt_a - cnt_b) : (cnt_b - cnt_a);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      tmr     <= '0;
      sel_a_q <= '0;
      sel_b_q <= '0;
      cnt_a   <= '0;
      cnt_b   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.start) begin
            state   <= ST_SETTLE;
            tmr     <= TW'(SETTLE - 1);
            sel_a_q <= bus.sel_a;
            sel_b_q <= bus.sel_b;
            cnt_a   <= '0;
            cnt_b   <= '0;
          end
        end
        ST_SETTLE: begin
          if (tmr == '0) begin
            state <= ST_COUNT;
            tmr   <= TW'(WINDOW - 1);
          end else begin
            tmr <= tmr - 1'b1;
          end
        end
        ST_COUNT: begin
          if (edge_a && (cnt_a != '1)) cnt_a <= cnt_a + 1'b1;
          if (edge_b && (cnt_b != '1)) cnt_b <= cnt_b + 1'b1;
          if (tmr == '0) state <= ST_DONE;
          else           tmr   <= tmr - 1'b1;
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Results are captured from the settled counts one cycle after the last counted edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      done_q <= 1'b0;
      resp_q <= 1'b0;
      diff_q <= '0;
    end else begin
      done_q <= (state == ST_DONE);
      if (state == ST_DONE) begin
        resp_q <= (cnt_a > cnt_b);
        diff_q <= absdiff;
      end
    end
  end

`ifdef PUF_MARGIN_EN
  logic unstable_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                    unstable_q <= 1'b0;
    else if (state == ST_DONE)  unstable_q <= (absdiff < CW'(MARGIN));
  end

  assign bus.unstable = unstable_q;
`endif

  assign ro_en    = (state == ST_SETTLE) || (state == ST_COUNT);
  assign bus.busy = ro_en;
  assign bus.done = done_q;
  assign bus.resp = resp_q;
  assign bus.diff = diff_q;
endmodule

// File: tb/tb_ro_puf_reader.sv
// Bench for ro_puf_reader: oscillators are modelled as periodic waves stepped on the falling
// clock edge, and expected counts come from counting wave rises over the delayed window.
module tb_ro_puf_reader;
  localparam int N_RO   = 16;
  localparam int S      = 16;
  localparam int W      = 1024;
  localparam int MARGIN = 8;

  logic            clk = 1'b0;
  logic            rst;
  logic [N_RO-1:0] ro_in;
  logic            ro_en1;
  logic            ro_en2;

  int cyc       = 0;
  int vectors   = 0;
  int miss      = 0;
  int done_cnt1 = 0;
  int done_cnt2 = 0;
  int per [N_RO];
  int ph  [N_RO];

  ro_puf_reader_if #(.N_RO(N_RO), .CW(16)) if1 ();
  ro_puf_reader_if #(.N_RO(N_RO), .CW(4))  if2 ();

  ro_puf_reader #(.N_RO(N_RO), .CW(16), .WINDOW(W), .SETTLE(S), .MARGIN(MARGIN)) dut (
    .clk(clk), .rst(rst), .ro_in(ro_in), .ro_en(ro_en1), .bus(if1.slave));

  ro_puf_reader #(.N_RO(N_RO), .CW(4), .WINDOW(W), .SETTLE(S), .MARGIN(MARGIN)) dut_sat (
    .clk(clk), .rst(rst), .ro_in(ro_in), .ro_en(ro_en2), .bus(if2.slave));

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int wave(int i, int c);
    return (((c + ph[i]) % per[i]) < (per[i] / 2)) ? 1 : 0;
  endfunction

  // Edge counted at posedge p reflects the input sampled at posedge p-2; window is posedges T0+S+1..T0+S+W.
  function automatic int count_edges(int i, int t0, int maxv);
    int n = 0;
    if (i >= N_RO) return 0;
    for (int q = t0 + S - 1; q <= t0 + S + W - 2; q++)
      if (wave(i, q) == 1 && wave(i, q - 1) == 0) n++;
    return (n > maxv) ? maxv : n;
  endfunction

  always @(negedge clk)
    for (int i = 0; i < N_RO; i++) ro_in[i] = (wave(i, cyc + 1) != 0);

  always @(negedge clk) begin
    if (if1.done === 1'b1) done_cnt1++;
    if (if2.done === 1'b1) done_cnt2++;
  end

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miss++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic eval1(int a, int b, bit extra_start);
    int t0, k, base, ea, eb, d;
    @(negedge clk);
    if1.sel_a = a[3:0];
    if1.sel_b = b[3:0];
    if1.start = 1'b1;
    @(posedge clk); #1;
    t0 = cyc;
    if1.start = 1'b0;
    if1.sel_a = 4'($urandom_range(0, 15));
    if1.sel_b = 4'($urandom_range(0, 15));
    base = done_cnt1;
    check("busy_after_start", if1.busy, 1);
    check("ro_en_after_start", ro_en1, 1);
    ea = count_edges(a, t0, 65535);
    eb = count_edges(b, t0, 65535);
    d  = (ea > eb) ? ea - eb : eb - ea;
    k = 0;
    while (if1.done !== 1'b1 && k < S + W + 20) begin
      @(posedge clk); #1;
      k++;
      if (extra_start) if1.start = (cyc == t0 + 99);
    end
    if1.start = 1'b0;
    check("done_seen", if1.done, 1);
    check("done_time", cyc, t0 + S + W + 1);
    check("busy_in_done", if1.busy, 0);
    check("ro_en_in_done", ro_en1, 0);
    check("resp", if1.resp, (ea > eb) ? 1 : 0);
    check("diff", if1.diff, d);
`ifdef PUF_MARGIN_EN
    check("unstable", if1.unstable, (d < MARGIN) ? 1 : 0);
`endif
    repeat (3) @(posedge clk);
    #1;
    check("done_pulses", done_cnt1 - base, 1);
    check("done_low_after", if1.done, 0);
  endtask

  task automatic eval2(int a, int b);
    int t0, k, ea, eb;
    @(negedge clk);
    if2.sel_a = a[3:0];
    if2.sel_b = b[3:0];
    if2.start = 1'b1;
    @(posedge clk); #1;
    t0 = cyc;
    if2.start = 1'b0;
    ea = count_edges(a, t0, 15);
    eb = count_edges(b, t0, 15);
    k = 0;
    while (if2.done !== 1'b1 && k < S + W + 20) begin
      @(posedge clk); #1;
      k++;
    end
    check("sat_done_time", cyc, t0 + S + W + 1);
    check("sat_resp", if2.resp, (ea > eb) ? 1 : 0);
    check("sat_diff", if2.diff, (ea > eb) ? ea - eb : eb - ea);
    check("sat_ro_en", ro_en2, 0);
  endtask

  initial begin
    int t0, base;
    for (int i = 0; i < N_RO; i++) begin
      per[i] = 8;
      ph[i]  = 0;
    end
    rst = 1'b1;
    if1.start = 1'b0; if1.sel_a = '0; if1.sel_b = '0;
    if2.start = 1'b0; if2.sel_a = '0; if2.sel_b = '0;
    repeat (4) @(posedge clk);
    #1;
    check("rst_busy", if1.busy, 0);
    check("rst_ro_en", ro_en1, 0);
    check("rst_done", if1.done, 0);
    check("rst_resp", if1.resp, 0);
    check("rst_diff", if1.diff, 0);
    check("rst_sat_diff", if2.diff, 0);
`ifdef PUF_MARGIN_EN
    check("rst_unstable", if1.unstable, 0);
`endif
    @(negedge clk) rst = 1'b0;
    repeat (3) @(posedge clk);

    // 80 ns vs 100 ns oscillators, plus a start pulse during COUNT that must be ignored
    per[2] = 8;
    per[5] = 10;
    ph[5]  = 3;
    eval1(2, 5, 1'b1);

    // reset mid-evaluation
    @(negedge clk);
    if1.sel_a = 4'd2; if1.sel_b = 4'd5; if1.start = 1'b1;
    @(posedge clk); #1;
    t0 = cyc;
    if1.start = 1'b0;
    base = done_cnt1;
    while (cyc < t0 + 500) begin
      @(posedge clk); #1;
    end
    #2 rst = 1'b1;
    #1;
    check("abort_busy", if1.busy, 0);
    check("abort_ro_en", ro_en1, 0);
    check("abort_resp", if1.resp, 0);
    check("abort_diff", if1.diff, 0);
    @(negedge clk) rst = 1'b0;
    repeat (S + W + 10) @(posedge clk);
    #1;
    check("abort_no_done", done_cnt1 - base, 0);

    eval1(2, 5, 1'b0);
    eval1(5, 2, 1'b0);
    eval1(2, 2, 1'b0);

    // close frequencies: small diff
    per[7] = 8;
    per[9] = 8;
    ph[9]  = 5;
    eval1(7, 9, 1'b0);

    for (int t = 0; t < 8; t++) begin
      int a, b;
      for (int i = 0; i < N_RO; i++) begin
        per[i] = $urandom_range(4, 24);
        ph[i]  = $urandom_range(0, per[i] - 1);
      end
      a = $urandom_range(0, N_RO - 1);
      b = ($urandom_range(0, 3) == 0) ? a : $urandom_range(0, N_RO - 1);
      eval1(a, b, 1'b0);
    end

    // 4-bit counters saturate at 15
    per[2] = 8;
    per[5] = 8;
    ph[5]  = 2;
    eval2(2, 5);
    per[5] = 10;
    eval2(5, 2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miss);
    $finish;
  end
endmodule
